// File: rtl/spi_mem_slave.sv
// SPI mode-0 slave scratch memory, fully synchronous to clk. The SPI pins are oversampled,
// edge-detected, and then drive a command/data FSM over a small register-file memory.
module spi_mem_slave #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_strobe,
  output logic              rd_strobe,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sclk_prev;
  logic                   r_cs_prev;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_cur_addr;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-2:0]      r_shift_in;
  logic [DATA_W-2:0]      r_shift_out;
  logic                   r_load_pending;
  logic                   r_miso;
  logic                   r_miso_oe;
  logic                   r_wr_strobe;
  logic                   r_rd_strobe;
  logic [DATA_W-1:0]      r_mem [DEPTH];

  logic                   w_sclk_s;
  logic                   w_mosi_s;
  logic                   w_cs_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_byte_done;
  logic [DATA_W-1:0]      w_byte;
  logic [DATA_W-1:0]      w_rd_word;
  logic                   w_wr_en;

  // cs synchroniser flops reset to 1 so that a reset never looks like a select.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk_s & ~r_sclk_prev;
  assign w_fall      = ~w_sclk_s & r_sclk_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;
  assign w_cs_rise   = w_cs_s & ~r_cs_prev;
  assign w_byte      = {r_shift_in, w_mosi_s};
  assign w_byte_done = w_rise & ~w_cs_s & (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_wr_en     = (r_state == ST_WDATA) & w_byte_done;
  assign w_rd_word   = r_mem[r_cur_addr];

  // NOTE: memory clears on reset, so it must stay in flops; a RAM macro cannot do this.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_cur_addr] <= w_byte;
    end
  end

  // NOTE: all state uses <= so every branch reads pre-edge values; the cs-rise block
  // at the end deliberately overrides the state set inside the case.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cur_addr     <= '0;
      r_bit_cnt      <= '0;
      r_shift_in     <= '0;
      r_shift_out    <= '0;
      r_load_pending <= 1'b0;
      r_miso         <= 1'b0;
      r_miso_oe      <= 1'b0;
      r_wr_strobe    <= 1'b0;
      r_rd_strobe    <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;

      if (w_rise && !w_cs_s) begin
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        r_shift_in <= w_byte[DATA_W-2:0];
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ST_CMD;
            r_bit_cnt <= '0;
            r_miso_oe <= 1'b1;
          end
        end
        ST_CMD: begin
          if (w_byte_done) begin
            r_cur_addr <= w_byte[ADDR_W-1:0];
            if (w_byte[DATA_W-1]) begin
              r_state <= ST_WDATA;
            end else begin
              r_state        <= ST_RDATA;
              r_load_pending <= 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (w_byte_done) begin
            r_wr_strobe <= 1'b1;
            r_cur_addr  <= r_cur_addr + ADDR_W'(1);
          end
        end
        ST_RDATA: begin
          if (w_byte_done) begin
            r_cur_addr     <= r_cur_addr + ADDR_W'(1);
            r_load_pending <= 1'b1;
          end
          // miso only moves on a falling edge, so it is settled for the master's next rise.
          if (w_fall) begin
            if (r_load_pending) begin
              r_shift_out    <= w_rd_word[DATA_W-2:0];
              r_miso         <= w_rd_word[DATA_W-1];
              r_rd_strobe    <= 1'b1;
              r_load_pending <= 1'b0;
            end else begin
              r_shift_out <= {r_shift_out[DATA_W-3:0], 1'b0};
              r_miso      <= r_shift_out[DATA_W-2];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_cs_rise) begin
        r_state        <= ST_IDLE;
        r_miso         <= 1'b0;
        r_miso_oe      <= 1'b0;
        r_load_pending <= 1'b0;
      end
    end
  end

  assign miso      = r_miso;
  assign miso_oe   = r_miso_oe;
  assign wr_strobe = r_wr_strobe;
  assign rd_strobe = r_rd_strobe;
  assign cur_addr  = r_cur_addr;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_data  = r_mem[dbg_addr];

endmodule

// File: tb/tb_spi_mem_slave.sv
// Self-checking bench for spi_mem_slave: a bit-banged mode-0 master plus an array model
// of the memory and address pointer, with directed and randomized transactions.
module tb_spi_mem_slave;

  localparam int SYNC = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       wr_strobe;
  logic       rd_strobe;
  logic [3:0] cur_addr;
  logic       busy;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;

  spi_mem_slave #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .wr_strobe(wr_strobe),
    .rd_strobe(rd_strobe),
    .cur_addr (cur_addr),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int n_rd     = 0;
  int half     = 4;
  int rd_before_fall = 0;

  logic       q_bits [$];
  logic [7:0] q_tx   [$];
  logic [7:0] exp_rx [$];
  logic [7:0] m_mem  [16];
  logic [3:0] m_addr;

  always @(posedge clk) begin
    if (wr_strobe) n_wr++;
    if (rd_strobe) n_rd++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bits are driven while sclk is low; miso is sampled when the slave sees the rise,
  // i.e. SYNC clocks after the pin rises.
  task automatic spi_bit(input logic b);
    mosi = b;
    repeat (half) @(negedge clk);
    sclk = 1'b1;
    fork
      begin
        repeat (SYNC) @(negedge clk);
        q_bits.push_back(miso);
      end
    join_none
    repeat (half) @(negedge clk);
    rd_before_fall = n_rd;
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i]);
  endtask

  task automatic spi_txn(input logic [7:0] cmd, input int n);
    q_bits.delete();
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(cmd);
    for (int k = 0; k < n; k++) spi_byte(k < q_tx.size() ? q_tx[k] : 8'h00);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) v = {v[6:0], q_bits[8 * (k + 1) + b]};
    return v;
  endfunction

  task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Model: writes land at start+k mod 16, reads return the same locations, the pointer
  // ends at start+n. A read also prefetches on the master's final falling edge.
  task automatic do_txn(input string tag, input logic [7:0] cmd, input int n);
    int wr0;
    int rd0;
    logic [3:0] idx;
    wr0 = n_wr;
    rd0 = n_rd;
    exp_rx.delete();
    for (int k = 0; k < n; k++) begin
      idx = 4'((int'(cmd[3:0]) + k) % 16);
      if (cmd[7]) m_mem[idx] = q_tx[k];
      else exp_rx.push_back(m_mem[idx]);
    end
    m_addr = 4'((int'(cmd[3:0]) + n) % 16);
    spi_txn(cmd, n);
    chk({tag, ".cur_addr"}, cur_addr, m_addr);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".miso_oe"}, miso_oe, 1'b0);
    if (cmd[7]) begin
      chk({tag, ".wr_cnt"}, n_wr - wr0, n);
      chk({tag, ".rd_cnt"}, n_rd - rd0, 0);
    end else begin
      chk({tag, ".wr_cnt"}, n_wr - wr0, 0);
      chk({tag, ".rd_cnt"}, n_rd - rd0, n + 1);
      for (int k = 0; k < n; k++) chk($sformatf("%s.rx%0d", tag, k), rx_byte(k), exp_rx[k]);
    end
  endtask

  initial begin
    int wr0;
    int rd0;
    logic [7:0] cmd;
    int n;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_addr = '0;
    repeat (5) @(negedge clk);
    chk("por.busy", busy, 1'b0);
    chk("por.miso_oe", miso_oe, 1'b0);
    chk("por.miso", miso, 1'b0);
    chk("por.cur_addr", cur_addr, 4'h0);
    chk("por.strobes", {wr_strobe, rd_strobe}, 2'b00);
    rst = 1'b0;
    repeat (SYNC + 2) @(negedge clk);

    // Fill some memory, then reset in the middle of a command byte.
    q_tx = '{8'($urandom_range(255, 1)), 8'($urandom_range(255, 1))};
    do_txn("prep", 8'h86, 2);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
    chk("mid.busy_before", busy, 1'b1);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.miso_oe", miso_oe, 1'b0);
    chk("rst.cur_addr", cur_addr, 4'h0);
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 8'h00;
      peek($sformatf("rst.mem%0d", i), 4'(i), 8'h00);
    end
    m_addr = '0;
    cs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (SYNC + 2) @(negedge clk);

    q_tx = '{8'hA5};
    do_txn("single", 8'h83, 1);
    peek("single.mem3", 4'd3, 8'hA5);
    chk("single.cur_addr4", cur_addr, 4'd4);

    q_tx = '{8'h11, 8'h22, 8'h33};
    do_txn("burst", 8'h8F, 3);
    peek("burst.mem15", 4'd15, 8'h11);
    peek("burst.mem0", 4'd0, 8'h22);
    peek("burst.mem1", 4'd1, 8'h33);

    q_tx.delete();
    do_txn("read", 8'h0F, 2);
    chk("read.byte0", rx_byte(0), 8'h11);
    chk("read.byte1", rx_byte(1), 8'h22);
    chk("read.rd_at_last_rise", rd_before_fall - (n_rd - 3), 2);

    // Abort: command plus 5 data bits, then deselect.
    wr0 = n_wr;
    q_bits.delete();
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h85);
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(1, 0)));
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC) @(negedge clk);
    chk("abort.oe_before", miso_oe, 1'b1);
    @(negedge clk);
    chk("abort.oe_after", miso_oe, 1'b0);
    chk("abort.busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    peek("abort.mem5", 4'd5, m_mem[5]);
    chk("abort.wr_cnt", n_wr - wr0, 0);
    chk("abort.cur_addr", cur_addr, 4'd5);
    m_addr = 4'd5;

    // Minimum sclk timing: 2 clk high / 2 clk low.
    half = 2;
    q_tx = '{8'h5A};
    do_txn("fast_wr", 8'h89, 1);
    q_tx.delete();
    do_txn("fast_rd", 8'h09, 1);
    chk("fast.byte", rx_byte(0), 8'h5A);

    // Randomized traffic; ignored command bits are randomized too.
    for (int t = 0; t < 10; t++) begin
      half = $urandom_range(5, 2);
      n = $urandom_range(3, 1);
      cmd = {1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), 4'($urandom_range(15, 0))};
      q_tx.delete();
      for (int k = 0; k < n; k++) q_tx.push_back(8'($urandom_range(255, 0)));
      do_txn($sformatf("rnd%0d", t), cmd, n);
    end

    for (int i = 0; i < 16; i++) peek($sformatf("final.mem%0d", i), 4'(i), m_mem[i]);

    rd0 = n_rd;
    repeat (20) @(negedge clk);
    chk("idle.no_rd", n_rd - rd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
